// File: rtl/cpu_debug_pkg.sv
// Shared definitions for the CPU debug controller.
//   - FSM state encoding
//   - halt_cause codes reported through CTRL and the halt_cause port
//   - register window offsets and CTRL bit positions
package cpu_debug_pkg;

    typedef enum logic [2:0] {
        ST_RUN       = 3'd0,
        ST_STOP      = 3'd1,
        ST_ARMED     = 3'd2,
        ST_STEPWAIT  = 3'd3,
        ST_RESETSTEP = 3'd4
    } dbg_state_e;

    localparam logic [1:0] CAUSE_NONE   = 2'd0;
    localparam logic [1:0] CAUSE_MANUAL = 2'd1;
    localparam logic [1:0] CAUSE_STEP   = 2'd2;
    localparam logic [1:0] CAUSE_BP     = 2'd3;

    localparam logic [3:0] OFF_CTRL    = 4'd0;
    localparam logic [3:0] OFF_STEPCNT = 4'd1;
    localparam logic [3:0] OFF_BPEN    = 4'd2;
    // Breakpoint i occupies offsets BP_REG_BASE+2i (low) and BP_REG_BASE+2i+1 (high).
    localparam int         BP_REG_BASE = 4;

    localparam int CTRL_ARM_BIT   = 7;
    localparam int CTRL_CLEAR_BIT = 6;

    localparam int STEP_CNT_W = 11;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector.
//   clk, rst_n : clock, asynchronous active-low reset
//   din        : level input (sampled every clk)
//   rise       : high for the cycle in which din is 1 and was 0 on the previous clk
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q <= 1'b0;
        end else begin
            din_q <= din;
        end
    end

    assign rise = din & ~din_q;

endmodule

// File: rtl/cpu_debug_ctrl.sv
// CPU debug controller: halts a CPU via NMI on button press, single-step
// completion or hardware breakpoint, and exposes a 16-byte register window
// to the monitor program.
//   clk, rst_n                  : clock, asynchronous active-low reset
//   a, write, din               : monitor bus address, write strobe, write data
//   dout                        : registered read data (one clk after a)
//   hit                         : a lies inside the register window
//   sync, cpu_addr              : CPU opcode-fetch indicator and address bus
//   b_step, b_runhalt, b_reset  : single-cycle button pulses
//   nmi_start                   : one-cycle NMI request
//   stopped                     : controller is in STOP
//   halt_cause                  : 0 none, 1 manual, 2 step, 3 breakpoint
module cpu_debug_ctrl #(
    parameter int         NUM_BP        = 2,
    parameter int         SYNC_PER_STEP = 3,
    parameter logic [7:0] WIN_BASE      = 8'hE0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  a,
    input  logic        write,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    output logic        hit,
    input  logic        sync,
    input  logic [15:0] cpu_addr,
    input  logic        b_step,
    input  logic        b_runhalt,
    input  logic        b_reset,
    output logic        nmi_start,
    output logic        stopped,
    output logic [1:0]  halt_cause
);
    import cpu_debug_pkg::*;

    dbg_state_e              state, state_nxt;
    logic                    sync_rise;
    logic                    arm;
    logic [7:0]              stepcnt_reg;
    logic [NUM_BP-1:0]       bpen;
    logic [15:0]             bp_addr [NUM_BP];
    logic [STEP_CNT_W-1:0]   step_cnt;
    logic [STEP_CNT_W-1:0]   step_init;
    logic [7:0]              stepcnt_eff;
    logic [2:0]              skip_cnt;
    logic [3:0]              off;
    logic                    wr_en;
    logic                    ctrl_wr;
    logic                    bp_match;
    logic                    bp_fire;
    logic [7:0]              rd_data;

    // FSM side effects decided combinationally, committed by the registers below.
    logic                    nmi_nxt;
    logic                    cause_set;
    logic [1:0]              cause_val;
    logic                    skip_load;
    logic                    step_load;
    logic                    arm_clr;

    edge_detect u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (sync),
        .rise  (sync_rise)
    );

    // The window is 16-aligned, so the upper nibble selects it and the lower is the offset.
    assign hit     = (a[7:4] == WIN_BASE[7:4]);
    assign off     = a[3:0];
    assign wr_en   = write & hit;
    assign ctrl_wr = wr_en && (off == OFF_CTRL);
    assign stopped = (state == ST_STOP);

    // A step count of 0 behaves as 1; the return path through the monitor
    // consumes SYNC_PER_STEP-1 extra fetches before the user instructions.
    assign stepcnt_eff = (stepcnt_reg == 8'd0) ? 8'd1 : stepcnt_reg;
    assign step_init   = STEP_CNT_W'(SYNC_PER_STEP)
                       + {{(STEP_CNT_W-8){1'b0}}, stepcnt_eff}
                       - STEP_CNT_W'(1);

    always_comb begin
        bp_match = 1'b0;
        for (int i = 0; i < NUM_BP; i++) begin
            if (bpen[i] && (bp_addr[i] == cpu_addr)) begin
                bp_match = 1'b1;
            end
        end
    end

    // Breakpoints stay masked until the monitor's own return fetches are consumed.
    assign bp_fire = sync_rise && bp_match && (skip_cnt == 3'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        nmi_nxt   = 1'b0;
        cause_set = 1'b0;
        cause_val = CAUSE_NONE;
        skip_load = 1'b0;
        step_load = 1'b0;
        arm_clr   = 1'b0;
        case (state)
            ST_RUN: begin
                if (b_step || b_runhalt) begin
                    state_nxt = ST_STOP;
                    nmi_nxt   = 1'b1;
                    cause_set = 1'b1;
                    cause_val = CAUSE_MANUAL;
                end else if (bp_fire) begin
                    state_nxt = ST_STOP;
                    nmi_nxt   = 1'b1;
                    cause_set = 1'b1;
                    cause_val = CAUSE_BP;
                end
            end
            ST_STOP: begin
                if (b_reset) begin
                    state_nxt = ST_RESETSTEP;
                    skip_load = 1'b1;
                end else if (b_runhalt) begin
                    state_nxt = ST_RUN;
                    skip_load = 1'b1;
                end else if (b_step) begin
                    state_nxt = ST_ARMED;
                    skip_load = 1'b1;
                    arm_clr   = 1'b1;
                end
            end
            ST_ARMED: begin
                if (b_reset) begin
                    state_nxt = ST_RUN;
                end else if (arm) begin
                    state_nxt = ST_STEPWAIT;
                    step_load = 1'b1;
                end
            end
            ST_STEPWAIT: begin
                if (b_reset) begin
                    state_nxt = ST_RUN;
                end else if (bp_fire) begin
                    state_nxt = ST_STOP;
                    nmi_nxt   = 1'b1;
                    cause_set = 1'b1;
                    cause_val = CAUSE_BP;
                end else if (sync_rise && (step_cnt == STEP_CNT_W'(1))) begin
                    state_nxt = ST_STOP;
                    nmi_nxt   = 1'b1;
                    cause_set = 1'b1;
                    cause_val = CAUSE_STEP;
                end
            end
            ST_RESETSTEP: begin
                if (b_reset) begin
                    state_nxt = ST_RUN;
                end else if (sync_rise) begin
                    state_nxt = ST_STOP;
                    nmi_nxt   = 1'b1;
                    cause_set = 1'b1;
                    cause_val = CAUSE_STEP;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nmi_start  <= 1'b0;
            halt_cause <= CAUSE_NONE;
            arm        <= 1'b0;
            skip_cnt   <= 3'd0;
            step_cnt   <= '0;
        end else begin
            nmi_start <= nmi_nxt;

            // A new stop reason beats a simultaneous clear from the monitor.
            if (cause_set) begin
                halt_cause <= cause_val;
            end else if (ctrl_wr && din[CTRL_CLEAR_BIT]) begin
                halt_cause <= CAUSE_NONE;
            end

            if (arm_clr) begin
                arm <= 1'b0;
            end else if (ctrl_wr && din[CTRL_ARM_BIT]) begin
                arm <= 1'b1;
            end

            if (skip_load) begin
                skip_cnt <= 3'(SYNC_PER_STEP);
            end else if (!stopped && sync_rise && (skip_cnt != 3'd0)) begin
                skip_cnt <= skip_cnt - 3'd1;
            end

            if (step_load) begin
                step_cnt <= step_init;
            end else if ((state == ST_STEPWAIT) && sync_rise && (step_cnt != '0)) begin
                step_cnt <= step_cnt - STEP_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stepcnt_reg <= 8'd0;
            bpen        <= '0;
            for (int i = 0; i < NUM_BP; i++) begin
                bp_addr[i] <= 16'd0;
            end
        end else if (wr_en) begin
            case (off)
                OFF_STEPCNT: stepcnt_reg <= din;
                OFF_BPEN:    bpen        <= din[NUM_BP-1:0];
                default: begin
                    for (int i = 0; i < NUM_BP; i++) begin
                        if (off == 4'(BP_REG_BASE + 2*i)) begin
                            bp_addr[i][7:0] <= din;
                        end
                        if (off == 4'(BP_REG_BASE + 2*i + 1)) begin
                            bp_addr[i][15:8] <= din;
                        end
                    end
                end
            endcase
        end
    end

    always_comb begin
        rd_data = 8'h00;
        case (off)
            OFF_CTRL:    rd_data = {stopped, halt_cause, 5'b0};
            OFF_STEPCNT: rd_data = stepcnt_reg;
            OFF_BPEN:    rd_data = 8'(bpen);
            default: begin
                for (int i = 0; i < NUM_BP; i++) begin
                    if (off == 4'(BP_REG_BASE + 2*i)) begin
                        rd_data = bp_addr[i][7:0];
                    end
                    if (off == 4'(BP_REG_BASE + 2*i + 1)) begin
                        rd_data = bp_addr[i][15:8];
                    end
                end
            end
        endcase
    end

    // Read data is sampled before this edge's write lands, so dout shows the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout <= 8'h00;
        end else begin
            dout <= hit ? rd_data : 8'h00;
        end
    end

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Self-checking bench for cpu_debug_ctrl (default parameters).
module tb_cpu_debug_ctrl;

    localparam int         NUM_BP        = 2;
    localparam int         SYNC_PER_STEP = 3;
    localparam logic [7:0] WIN_BASE      = 8'hE0;

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic        write;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        hit;
    logic        sync;
    logic [15:0] cpu_addr;
    logic        b_step;
    logic        b_runhalt;
    logic        b_reset;
    logic        nmi_start;
    logic        stopped;
    logic [1:0]  halt_cause;

    int checks = 0;
    int errors = 0;

    cpu_debug_ctrl #(
        .NUM_BP        (NUM_BP),
        .SYNC_PER_STEP (SYNC_PER_STEP),
        .WIN_BASE      (WIN_BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .write      (write),
        .din        (din),
        .dout       (dout),
        .hit        (hit),
        .sync       (sync),
        .cpu_addr   (cpu_addr),
        .b_step     (b_step),
        .b_runhalt  (b_runhalt),
        .b_reset    (b_reset),
        .nmi_start  (nmi_start),
        .stopped    (stopped),
        .halt_cause (halt_cause)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    localparam int M_RUN = 0, M_STOP = 1, M_ARMED = 2, M_STEP = 3, M_RSTEP = 4;

    int         m_mode  = M_RUN;
    int         m_skip  = 0;
    int         m_steps = 0;
    int         m_old;
    logic       m_arm   = 1'b0;
    logic [1:0] m_cause = 2'd0;
    logic       m_nmi   = 1'b0;
    logic [7:0] m_dout  = 8'h00;
    logic [7:0] m_mem [16];
    logic       m_prev  = 1'b0;
    logic       m_edge, m_bp, m_cause_set, m_arm_clr;
    logic [3:0] m_off;

    function automatic logic m_in_window(input logic [7:0] addr);
        return (int'(addr) >= int'(WIN_BASE)) && (int'(addr) <= int'(WIN_BASE) + 15);
    endfunction

    function automatic logic [7:0] m_mask(input logic [3:0] o);
        if (o == 4'd1) return 8'hFF;
        if (o == 4'd2) return 8'((1 << NUM_BP) - 1);
        if (int'(o) >= 4 && int'(o) < 4 + 2*NUM_BP) return 8'hFF;
        return 8'h00;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mode = M_RUN; m_skip = 0; m_steps = 0; m_arm = 0;
            m_cause = 0; m_nmi = 0; m_dout = 0; m_prev = 0;
            for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        end else begin
            m_edge = sync && !m_prev;
            m_prev = sync;
            m_off  = 4'(int'(a) - int'(WIN_BASE));
            m_bp   = 1'b0;
            for (int i = 0; i < NUM_BP; i++)
                if (m_mem[2][i] && ({m_mem[5+2*i], m_mem[4+2*i]} == cpu_addr)) m_bp = 1'b1;
            m_bp = m_bp && m_edge && (m_skip == 0);
            if (m_in_window(a))
                m_dout = (m_off == 0) ? {(m_mode == M_STOP), m_cause, 5'b0} : m_mem[m_off];
            else
                m_dout = 8'h00;
            m_old = m_mode;
            m_nmi = 0; m_cause_set = 0; m_arm_clr = 0;
            if (m_old != M_STOP && m_edge && m_skip > 0) m_skip--;
            case (m_old)
                M_RUN: begin
                    if (b_step || b_runhalt) begin m_mode = M_STOP; m_nmi = 1; m_cause = 1; m_cause_set = 1; end
                    else if (m_bp) begin m_mode = M_STOP; m_nmi = 1; m_cause = 3; m_cause_set = 1; end
                end
                M_STOP: begin
                    if (b_reset)        begin m_mode = M_RSTEP; m_skip = SYNC_PER_STEP; end
                    else if (b_runhalt) begin m_mode = M_RUN;   m_skip = SYNC_PER_STEP; end
                    else if (b_step)    begin m_mode = M_ARMED; m_skip = SYNC_PER_STEP; m_arm_clr = 1; m_arm = 0; end
                end
                M_ARMED: begin
                    if (b_reset) m_mode = M_RUN;
                    else if (m_arm) begin
                        m_mode  = M_STEP;
                        m_steps = SYNC_PER_STEP + ((m_mem[1] == 0) ? 1 : int'(m_mem[1])) - 1;
                    end
                end
                M_STEP: begin
                    if (b_reset) m_mode = M_RUN;
                    else if (m_bp) begin m_mode = M_STOP; m_nmi = 1; m_cause = 3; m_cause_set = 1; end
                    else if (m_edge) begin
                        m_steps--;
                        if (m_steps == 0) begin m_mode = M_STOP; m_nmi = 1; m_cause = 2; m_cause_set = 1; end
                    end
                end
                default: begin
                    if (b_reset) m_mode = M_RUN;
                    else if (m_edge) begin m_mode = M_STOP; m_nmi = 1; m_cause = 2; m_cause_set = 1; end
                end
            endcase
            if (write && m_in_window(a)) begin
                if (m_off == 0) begin
                    if (din[7] && !m_arm_clr) m_arm = 1;
                    if (din[6] && !m_cause_set) m_cause = 0;
                end else begin
                    m_mem[m_off] = din & m_mask(m_off);
                end
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_stopped",    {15'd0, stopped},    {15'd0, (m_mode == M_STOP)});
        chk("cmp_nmi_start",  {15'd0, nmi_start},  {15'd0, m_nmi});
        chk("cmp_halt_cause", {14'd0, halt_cause}, {14'd0, m_cause});
        chk("cmp_dout",       {8'd0, dout},        {8'd0, m_dout});
        chk("cmp_hit",        {15'd0, hit},        {15'd0, m_in_window(a)});
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input int which);
        if (which == 0) b_step = 1; else if (which == 1) b_runhalt = 1; else b_reset = 1;
        tick();
        b_step = 0; b_runhalt = 0; b_reset = 0;
    endtask

    task automatic wr(input logic [3:0] o, input logic [7:0] d);
        a = WIN_BASE + {4'd0, o}; write = 1; din = d;
        tick();
        write = 0; din = 0; a = 8'h00;
    endtask

    task automatic rd(input string name, input logic [3:0] o, input logic [7:0] exp);
        a = WIN_BASE + {4'd0, o};
        tick();
        chk(name, {8'd0, dout}, {8'd0, exp});
        a = 8'h00;
    endtask

    // Issues up to maxn sync edges; returns the 1-based edge number on which STOP was seen.
    task automatic run_edges(input logic [15:0] addr, input int maxn, output int stop_at);
        stop_at = 0;
        cpu_addr = addr;
        for (int k = 1; k <= maxn; k++) begin
            sync = 1;
            tick();
            if (stopped && stop_at == 0) stop_at = k;
            sync = 0;
            tick();
        end
        cpu_addr = 16'h0000;
    endtask

    task automatic arm_step(input logic [7:0] cnt);
        wr(4'd1, cnt);
        press(0);
        wr(4'd0, 8'h80);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n = 0; a = 0; write = 0; din = 0; sync = 0; cpu_addr = 0;
        b_step = 0; b_runhalt = 0; b_reset = 0;
        tick(); tick(); tick();
        chk("reset_stopped", {15'd0, stopped}, 16'd0);
        chk("reset_cause",   {14'd0, halt_cause}, 16'd0);
        chk("reset_nmi",     {15'd0, nmi_start}, 16'd0);
        chk("reset_dout",    {8'd0, dout}, 16'd0);
        rst_n = 1;
        tick();

        // Manual halt from RUN.
        press(1);
        chk("halt_nmi",     {15'd0, nmi_start}, 16'd1);
        chk("halt_stopped", {15'd0, stopped}, 16'd1);
        chk("halt_cause",   {14'd0, halt_cause}, 16'd1);
        tick();
        chk("halt_nmi_width", {15'd0, nmi_start}, 16'd0);
        rd("ctrl_read_a0", 4'd0, 8'hA0);

        // Register window.
        wr(4'd4, 8'h55);
        rd("bp0lo_55", 4'd4, 8'h55);
        rd("off3_zero", 4'd3, 8'h00);
        wr(4'd3, 8'hAA);
        rd("off3_ignored", 4'd3, 8'h00);
        wr(4'd2, 8'hFF);
        rd("bpen_upper_zero", 4'd2, 8'h03);
        wr(4'd8, 8'h77);
        rd("off8_beyond_bp", 4'd8, 8'h00);
        wr(4'd2, 8'h00);

        // Single step with STEPCNT=4: SYNC_PER_STEP+4-1 = 6 edges.
        arm_step(8'd4);
        run_edges(16'h0000, 9, n);
        chk("step4_edge", 16'(n), 16'd6);
        chk("step4_cause", {14'd0, halt_cause}, 16'd2);

        // STEPCNT=0 behaves as 1: 3 edges.
        arm_step(8'd0);
        run_edges(16'h0000, 6, n);
        chk("step0_edge", 16'(n), 16'd3);

        wr(4'd0, 8'h40);
        rd("ctrl_after_clear", 4'd0, 8'h80);

        // Breakpoint 0 at 1234.
        wr(4'd4, 8'h34);
        wr(4'd5, 8'h12);
        wr(4'd2, 8'h01);
        press(1);
        run_edges(16'h0000, 3, n);
        run_edges(16'h1234, 2, n);
        chk("bp_first_edge", 16'(n), 16'd1);
        chk("bp_cause", {14'd0, halt_cause}, 16'd3);
        press(1);
        run_edges(16'h1234, 6, n);
        chk("bp_resume_edge", 16'(n), 16'd4);
        chk("bp_resume_cause", {14'd0, halt_cause}, 16'd3);

        // Button beats a simultaneous breakpoint.
        press(1);
        run_edges(16'h0000, 3, n);
        wr(4'd0, 8'h40);
        cpu_addr = 16'h1234; sync = 1; b_step = 1;
        tick();
        chk("button_wins_cause", {14'd0, halt_cause}, 16'd1);
        sync = 0; b_step = 0; cpu_addr = 0;
        tick();

        // Abandon a step with b_reset.
        arm_step(8'd4);
        run_edges(16'h0000, 1, n);
        press(2);
        chk("abandon_stopped", {15'd0, stopped}, 16'd0);
        chk("abandon_nmi", {15'd0, nmi_start}, 16'd0);
        run_edges(16'h0000, 8, n);
        chk("abandon_no_stop", 16'(n), 16'd0);

        // Reset-step: STOP, b_reset, first sync edge stops.
        press(0);
        press(2);
        run_edges(16'h0000, 3, n);
        chk("resetstep_edge", 16'(n), 16'd1);
        chk("resetstep_cause", {14'd0, halt_cause}, 16'd2);

        // ARMED, b_reset returns to RUN; halt again manually.
        press(0);
        press(2);
        chk("armed_reset_run", {15'd0, stopped}, 16'd0);
        press(1);

        // Asynchronous reset during STEPWAIT.
        arm_step(8'd4);
        run_edges(16'h0000, 1, n);
        a = WIN_BASE;
        tick();
        chk("stepwait_ctrl", {8'd0, dout}, 16'h0020);
        a = 8'h00;
        @(negedge clk);
        #2;
        rst_n = 0;
        #1;
        chk("async_stopped", {15'd0, stopped}, 16'd0);
        chk("async_nmi",     {15'd0, nmi_start}, 16'd0);
        chk("async_cause",   {14'd0, halt_cause}, 16'd0);
        chk("async_dout",    {8'd0, dout}, 16'd0);
        tick();
        rst_n = 1;
        tick();
        rd("bpen_after_reset", 4'd2, 8'h00);
        rd("bp0_after_reset", 4'd4, 8'h00);
        press(1);
        chk("post_reset_run_halt", {14'd0, halt_cause}, 16'd1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
